// File: rtl/inst_boot_loader_if.sv
// Byte-stream input and instruction-SRAM write port of the boot loader.
// in_valid/in_data/in_ready: byte stream, accepted when in_valid & in_ready.
// ram_we/ram_addr/ram_wdata: one-cycle write pulse per assembled word.
interface inst_boot_loader_if;
  logic        in_valid;
  logic [7:0]  in_data;
  logic        in_ready;
  logic        ram_we;
  logic [31:0] ram_addr;
  logic [31:0] ram_wdata;

  // Image source / SRAM observer side.
  modport master (
    output in_valid, in_data,
    input  in_ready, ram_we, ram_addr, ram_wdata
  );

  // Boot loader side.
  modport slave (
    input  in_valid, in_data,
    output in_ready, ram_we, ram_addr, ram_wdata
  );
endinterface

// File: rtl/inst_boot_loader.sv
// Loads a program image from a byte stream into instruction SRAM, then releases the core.
// Latency: SRAM write one cycle after a word's 4th byte; cpu_resetn rises RELEASE_DELAY cycles after a good checksum.
// Backpressure: in_ready high while receiving (1 byte/cycle sustained), low once waiting, running or in error.
// Ports: clk, resetn (sync, active-low); bus = byte stream in + SRAM write port out;
//        cpu_resetn (core reset, active-low), boot_done / boot_err (sticky status).
module inst_boot_loader #(
  parameter logic [31:0] BASE_ADDR     = 32'h1c000000,
  parameter int          MAX_WORDS     = 1024,
  parameter int          RELEASE_DELAY = 4
) (
  input  logic                clk,
  input  logic                resetn,
  inst_boot_loader_if.slave   bus,
  output logic                cpu_resetn,
  output logic                boot_done,
  output logic                boot_err
);

  localparam int          CW          = (RELEASE_DELAY > 1) ? $clog2(RELEASE_DELAY) : 1;
  localparam logic [CW-1:0] CNT_LAST  = CW'(RELEASE_DELAY - 1);
  localparam logic [31:0] MAX_WORDS_U = 32'(MAX_WORDS);

  typedef enum logic [2:0] {
    S_HDR0, S_HDR1, S_LOAD, S_CHK, S_WAIT, S_RUN, S_ERR
  } state_t;

  state_t        state_q, state_d;
  logic [15:0]   n_q, n_d;
  logic [15:0]   idx_q, idx_d;
  logic [1:0]    bidx_q, bidx_d;
  logic [31:0]   word_q, word_d;
  logic [7:0]    acc_q, acc_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          in_ready_q, in_ready_d;
  logic          ram_we_q, ram_we_d;
  logic [31:0]   ram_addr_q, ram_addr_d;
  logic [31:0]   ram_wdata_q, ram_wdata_d;
  logic          cpu_resetn_q, cpu_resetn_d;
  logic          boot_done_q, boot_done_d;
  logic          boot_err_q, boot_err_d;

  logic accept;
  assign accept = bus.in_valid & in_ready_q;

  always_comb begin
    state_d     = state_q;
    n_d         = n_q;
    idx_d       = idx_q;
    bidx_d      = bidx_q;
    word_d      = word_q;
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    ram_we_d    = 1'b0;
    ram_addr_d  = ram_addr_q;
    ram_wdata_d = ram_wdata_q;

    case (state_q)
      S_HDR0: begin
        if (accept) begin
          n_d     = {n_q[15:8], bus.in_data};
          state_d = S_HDR1;
        end
      end
      S_HDR1: begin
        if (accept) begin
          n_d = {bus.in_data, n_q[7:0]};
          if ({16'h0000, n_d} > MAX_WORDS_U) state_d = S_ERR;
          else if (n_d == 16'h0000)          state_d = S_CHK;
          else                               state_d = S_LOAD;
        end
      end
      S_LOAD: begin
        if (accept) begin
          // Little-endian: shift in from the top so byte 0 lands in [7:0].
          word_d = {bus.in_data, word_q[31:8]};
          acc_d  = acc_q ^ bus.in_data;
          bidx_d = bidx_q + 2'd1;
          if (bidx_q == 2'd3) begin
            ram_we_d    = 1'b1;
            ram_wdata_d = word_d;
            ram_addr_d  = BASE_ADDR + {14'b0, idx_q, 2'b00};
            idx_d       = idx_q + 16'd1;
            if (idx_q == n_q - 16'd1) state_d = S_CHK;
          end
        end
      end
      S_CHK: begin
        if (accept) begin
          cnt_d   = '0;
          state_d = (bus.in_data == acc_q) ? S_WAIT : S_ERR;
        end
      end
      S_WAIT: begin
        if (cnt_q == CNT_LAST) state_d = S_RUN;
        else                   cnt_d   = cnt_q + CW'(1);
      end
      default: begin
        // S_RUN and S_ERR hold until resetn.
      end
    endcase

    // Outputs are registered from the next state so they are glitch-free
    // and line up with the state they describe.
    in_ready_d   = (state_d == S_HDR0) || (state_d == S_HDR1) ||
                   (state_d == S_LOAD) || (state_d == S_CHK);
    cpu_resetn_d = (state_d == S_RUN);
    boot_done_d  = (state_d == S_RUN);
    boot_err_d   = (state_d == S_ERR);
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q      <= S_HDR0;
      n_q          <= '0;
      idx_q        <= '0;
      bidx_q       <= '0;
      word_q       <= '0;
      acc_q        <= '0;
      cnt_q        <= '0;
      in_ready_q   <= 1'b1;
      ram_we_q     <= 1'b0;
      ram_addr_q   <= BASE_ADDR;
      ram_wdata_q  <= '0;
      cpu_resetn_q <= 1'b0;
      boot_done_q  <= 1'b0;
      boot_err_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      n_q          <= n_d;
      idx_q        <= idx_d;
      bidx_q       <= bidx_d;
      word_q       <= word_d;
      acc_q        <= acc_d;
      cnt_q        <= cnt_d;
      in_ready_q   <= in_ready_d;
      ram_we_q     <= ram_we_d;
      ram_addr_q   <= ram_addr_d;
      ram_wdata_q  <= ram_wdata_d;
      cpu_resetn_q <= cpu_resetn_d;
      boot_done_q  <= boot_done_d;
      boot_err_q   <= boot_err_d;
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.ram_we    = ram_we_q;
  assign bus.ram_addr  = ram_addr_q;
  assign bus.ram_wdata = ram_wdata_q;
  assign cpu_resetn    = cpu_resetn_q;
  assign boot_done     = boot_done_q;
  assign boot_err      = boot_err_q;

endmodule
